// File: rtl/bus_bridge_pkg.sv
// -----------------------------------------------------------------------------
// bus_bridge_pkg
// Shared constants for the CPU data-bus bridge: the peripheral page base, the
// peripheral register offsets within that page, and the seven-segment glyph
// table used by seg7_decode.
// -----------------------------------------------------------------------------
package bus_bridge_pkg;

    // Upper 20 address bits that select the peripheral page.
    localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;

    // Register offsets inside the peripheral page (addr[11:0]).
    localparam logic [11:0] OFF_DIGIT = 12'h000;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;
    localparam logic [11:0] OFF_BTN   = 12'h078;

    // Active-low glyphs, bit order {a,b,c,d,e,f,g,dp}; dp is always off (1).
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D,   // 0 1 2 3
        8'h99, 8'h49, 8'h41, 8'h1F,   // 4 5 6 7
        8'h01, 8'h09, 8'h11, 8'hC1,   // 8 9 A b
        8'h63, 8'h85, 8'h61, 8'h71    // C d E F
    };

endpackage : bus_bridge_pkg

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Purely combinational hex-to-seven-segment decoder.
//   hex : 4-bit nibble to display
//   seg : active-low segment drive {a,b,c,d,e,f,g,dp}
// -----------------------------------------------------------------------------
module seg7_decode
    import bus_bridge_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule : seg7_decode

// File: rtl/bus_bridge.sv
// -----------------------------------------------------------------------------
// bus_bridge
// Splits the CPU MEM-stage data bus between the data RAM and a small page of
// board peripherals (LEDs, switches, buttons, eight-digit seven-segment
// display), and scans the display.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   dram_we, addr, write_data  : CPU store strobe, byte address, store data
//   read_data                  : combinational load data back to the CPU
//   ram_we, ram_addr,
//   ram_wdata, ram_rdata       : data-RAM port (word addressed)
//   sw, button                 : asynchronous board inputs (synchronised here)
//   led                        : registered LED drive
//   dig_en, dig_seg            : registered, active-low display drive
// -----------------------------------------------------------------------------
module bus_bridge
    import bus_bridge_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int RAM_AW   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dram_we,
    input  logic [31:0]       addr,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [23:0]       sw,
    input  logic [4:0]        button,
    output logic [23:0]       led,
    output logic [7:0]        dig_en,
    output logic [7:0]        dig_seg
);

    // A 1-bit counter still works for SCAN_DIV==1: it sits at 0, which is
    // always the terminal count, so idx advances every cycle.
    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // ------------------------------------------------------------------ state
    logic [23:0]      led_q,      led_d;
    logic [31:0]      digit_q,    digit_d;
    logic [23:0]      sw_meta_q,  sw_meta_d;
    logic [23:0]      sw_sync_q,  sw_sync_d;
    logic [4:0]       btn_meta_q, btn_meta_d;
    logic [4:0]       btn_sync_q, btn_sync_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]       idx_q,      idx_d;
    logic [7:0]       dig_en_q,   dig_en_d;
    logic [7:0]       dig_seg_q,  dig_seg_d;

    // ------------------------------------------------------------ decoding
    logic        sel_periph;
    logic [11:0] offset;
    logic [3:0]  cur_nibble;
    logic [7:0]  cur_seg;

    assign sel_periph = (addr[31:12] == PERIPH_BASE);
    assign offset     = addr[11:0];

    // RAM port. ram_we is also held low during reset so an in-flight store
    // never lands in RAM while the bridge is being cleared.
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = write_data;
    assign ram_we    = dram_we & ~sel_periph & rst_n;

    assign cur_nibble = digit_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_seg7_decode (
        .hex (cur_nibble),
        .seg (cur_seg)
    );

    // Load path: unmapped offsets read as zero.
    always_comb begin
        read_data = 32'h0;
        if (!sel_periph) begin
            read_data = ram_rdata;
        end else begin
            case (offset)
                OFF_DIGIT: read_data = digit_q;
                OFF_LED:   read_data = {8'h0, led_q};
                OFF_SW:    read_data = {8'h0, sw_sync_q};
                OFF_BTN:   read_data = {27'h0, btn_sync_q};
                default:   read_data = 32'h0;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        led_d      = led_q;
        digit_d    = digit_q;
        scan_cnt_d = scan_cnt_q;
        idx_d      = idx_q;

        // Stores to SW/BTN or unmapped offsets fall through and change nothing.
        if (dram_we && sel_periph) begin
            case (offset)
                OFF_LED:   led_d   = write_data[23:0];
                OFF_DIGIT: digit_d = write_data;
                default:   ;
            endcase
        end

        // Two-flop synchronisers for the asynchronous board inputs.
        sw_meta_d  = sw;
        sw_sync_d  = sw_meta_q;
        btn_meta_d = button;
        btn_sync_d = btn_meta_q;

        // Scan timing runs independently of bus traffic; idx wraps 7 -> 0
        // through natural 3-bit overflow.
        if (scan_cnt_q == CNT_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + CNT_W'(1);
        end

        // Display outputs are registered copies of the current idx/DIGIT view.
        dig_en_d  = ~(8'h01 << idx_q);
        dig_seg_d = cur_seg;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q      <= '0;
            digit_q    <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            dig_en_q   <= 8'hFE;
            dig_seg_q  <= 8'h03;
        end else begin
            led_q      <= led_d;
            digit_q    <= digit_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            dig_en_q   <= dig_en_d;
            dig_seg_q  <= dig_seg_d;
        end
    end

    assign led     = led_q;
    assign dig_en  = dig_en_q;
    assign dig_seg = dig_seg_q;

endmodule : bus_bridge

// File: tb/tb_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_bus_bridge
// Self-checking bench for bus_bridge. Inputs change just after the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
// The display model derives the expected digit index from the number of
// rising edges since reset release: idx = (edges / SCAN_DIV) mod 8, and the
// registered outputs show the view from one edge earlier.
// -----------------------------------------------------------------------------
module tb_bus_bridge;

    localparam int SCAN_DIV = 4;
    localparam int RAM_AW   = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dram_we;
    logic [31:0]       addr;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [23:0]       sw;
    logic [4:0]        button;
    logic [23:0]       led;
    logic [7:0]        dig_en;
    logic [7:0]        dig_seg;

    bus_bridge #(.SCAN_DIV(SCAN_DIV), .RAM_AW(RAM_AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dram_we    (dram_we),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .sw         (sw),
        .button     (button),
        .led        (led),
        .dig_en     (dig_en),
        .dig_seg    (dig_seg)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Rising edges since reset release.
    int edge_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Standard hex glyphs, active-low {a,b,c,d,e,f,g,dp}.
    logic [7:0] glyph [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    // Reference register file.
    logic [23:0] ref_led;
    logic [31:0] ref_digit;

    localparam logic [31:0] A_DIGIT = 32'hFFFF_F000;
    localparam logic [31:0] A_LED   = 32'hFFFF_F060;
    localparam logic [31:0] A_SW    = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN   = 32'hFFFF_F078;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One store cycle; caller is positioned just after a falling edge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        dram_we = 1'b1; addr = a; write_data = d;
        @(negedge clk);
        dram_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dram_we = 1'b0; addr = 32'h0; write_data = 32'h0;
        ram_rdata = 32'h0; sw = 24'($urandom); button = 5'($urandom);
        repeat (3) @(negedge clk);
        #1;
        tests_run++; if (led !== 24'h0) begin tests_failed++; $display("FAIL reset_led got %h want 000000", led); end
        tests_run++; if (dig_en !== 8'hFE) begin tests_failed++; $display("FAIL reset_dig_en got %h want fe", dig_en); end
        tests_run++; if (dig_seg !== 8'h03) begin tests_failed++; $display("FAIL reset_dig_seg got %h want 03", dig_seg); end
        tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
        addr = A_SW; #1;
        tests_run++; if (read_data !== 32'h0) begin tests_failed++; $display("FAIL reset_sw_sync got %h want 0", read_data); end
        addr = A_DIGIT; #1;
        tests_run++; if (read_data !== 32'h0) begin tests_failed++; $display("FAIL reset_digit got %h want 0", read_data); end
        sw = 24'h0; button = 5'h0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_led = 24'h0; ref_digit = 32'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ram();
        logic [31:0] a;
        logic [31:0] d;
        @(negedge clk);
        ram_rdata = $urandom;
        dram_we = 1'b1; addr = 32'h0000_0010; write_data = 32'hDEADBEEF; #1;
        tests_run++; if (ram_we !== 1'b1) begin tests_failed++; $display("FAIL ram_store_we got %b want 1", ram_we); end
        tests_run++; if (ram_addr !== 14'd4) begin tests_failed++; $display("FAIL ram_store_addr got %0d want 4", ram_addr); end
        tests_run++; if (ram_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL ram_store_wdata got %h want deadbeef", ram_wdata); end
        @(negedge clk);
        dram_we = 1'b0; #1;
        tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL ram_idle_we got %b want 0", ram_we); end
        tests_run++; if (led !== ref_led) begin tests_failed++; $display("FAIL ram_led_untouched got %h want %h", led, ref_led); end
        tests_run++; if (read_data !== ram_rdata) begin tests_failed++; $display("FAIL ram_load got %h want %h", read_data, ram_rdata); end
        for (int i = 0; i < 8; i++) begin
            a = $urandom; a[1:0] = 2'b00;
            if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
            d = $urandom;
            @(negedge clk);
            ram_rdata = $urandom; dram_we = 1'b1; addr = a; write_data = d; #1;
            tests_run++;
            if (ram_we !== 1'b1 || ram_addr !== 14'((a >> 2) & ((1 << RAM_AW) - 1)) ||
                ram_wdata !== d || read_data !== ram_rdata) begin
                tests_failed++;
                $display("FAIL ram_rand addr %h got we=%b ra=%h wd=%h rd=%h want we=1 ra=%h wd=%h rd=%h",
                         a, ram_we, ram_addr, ram_wdata, read_data, 14'(a >> 2), d, ram_rdata);
            end
        end
        @(negedge clk);
        dram_we = 1'b0;
    endtask

    task automatic test_led();
        logic [31:0] d;
        @(negedge clk);
        dram_we = 1'b1; addr = A_LED; write_data = 32'hFF123456; #1;
        tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL led_store_ram_we got %b want 0", ram_we); end
        tests_run++; if (led !== ref_led) begin tests_failed++; $display("FAIL led_before_edge got %h want %h", led, ref_led); end
        @(negedge clk);
        dram_we = 1'b0; ref_led = 24'h123456; #1;
        tests_run++; if (led !== 24'h123456) begin tests_failed++; $display("FAIL led_value got %h want 123456", led); end
        tests_run++; if (read_data !== 32'h00123456) begin tests_failed++; $display("FAIL led_load got %h want 00123456", read_data); end
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            @(negedge clk);
            do_store(A_LED, d);
            ref_led = d[23:0];
            #1;
            tests_run++;
            if (led !== ref_led || read_data !== {8'h0, ref_led}) begin
                tests_failed++;
                $display("FAIL led_rand got led=%h rd=%h want %h", led, read_data, ref_led);
            end
        end
    endtask

    task automatic test_digit();
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            @(negedge clk);
            do_store(A_DIGIT, d);
            ref_digit = d;
            addr = A_DIGIT; #1;
            tests_run++;
            if (read_data !== ref_digit) begin tests_failed++; $display("FAIL digit_rand got %h want %h", read_data, ref_digit); end
        end
    endtask

    task automatic test_sync();
        logic [23:0] old_sw;
        logic [4:0]  old_btn;
        logic [4:0]  new_btn;
        old_sw = 24'($urandom); old_btn = 5'($urandom);
        @(negedge clk);
        sw = old_sw; button = old_btn;
        repeat (3) @(negedge clk);
        sw = 24'hA5A5A5; addr = A_SW; #1;
        tests_run++; if (read_data !== {8'h0, old_sw}) begin tests_failed++; $display("FAIL sw_edge0 got %h want %h", read_data, old_sw); end
        @(negedge clk); #1;
        tests_run++; if (read_data !== {8'h0, old_sw}) begin tests_failed++; $display("FAIL sw_edge1 got %h want %h", read_data, old_sw); end
        @(negedge clk); #1;
        tests_run++; if (read_data !== 32'h00A5A5A5) begin tests_failed++; $display("FAIL sw_edge2 got %h want 00a5a5a5", read_data); end
        addr = 32'hFFFF_F07C; #1;
        tests_run++; if (read_data !== 32'h0) begin tests_failed++; $display("FAIL unmapped_07c got %h want 0", read_data); end
        new_btn = ~old_btn;
        @(negedge clk);
        button = new_btn; addr = A_BTN; #1;
        tests_run++; if (read_data !== {27'h0, old_btn}) begin tests_failed++; $display("FAIL btn_edge0 got %h want %h", read_data, old_btn); end
        @(negedge clk); #1;
        tests_run++; if (read_data !== {27'h0, old_btn}) begin tests_failed++; $display("FAIL btn_edge1 got %h want %h", read_data, old_btn); end
        @(negedge clk); #1;
        tests_run++; if (read_data !== {27'h0, new_btn}) begin tests_failed++; $display("FAIL btn_edge2 got %h want %h", read_data, new_btn); end
    endtask

    // Stores to unmapped and read-only offsets change nothing and read as the
    // model says (zero for unmapped, synchronised pins for SW/BTN).
    task automatic test_unmapped();
        logic [11:0] off;
        for (int i = 0; i < 6; i++) begin
            off = 12'($urandom_range(0, 1023) * 4);
            if (off == 12'h000 || off == 12'h060 || off == 12'h070 || off == 12'h078) off = 12'h100;
            @(negedge clk);
            do_store({20'hFFFFF, off}, $urandom);
            addr = {20'hFFFFF, off}; #1;
            tests_run++;
            if (read_data !== 32'h0) begin tests_failed++; $display("FAIL unmapped_read off %h got %h want 0", off, read_data); end
        end
        @(negedge clk);
        do_store(A_SW, 32'hFFFFFFFF);
        do_store(A_BTN, 32'hFFFFFFFF);
        addr = A_SW; #1;
        tests_run++; if (read_data !== {8'h0, sw}) begin tests_failed++; $display("FAIL ro_sw_write got %h want %h", read_data, sw); end
        tests_run++; if (led !== ref_led) begin tests_failed++; $display("FAIL ro_led_untouched got %h want %h", led, ref_led); end
        addr = A_DIGIT; #1;
        tests_run++; if (read_data !== ref_digit) begin tests_failed++; $display("FAIL ro_digit_untouched got %h want %h", read_data, ref_digit); end
    endtask

    task automatic test_scan();
        int k;
        int i;
        @(negedge clk);
        do_store(A_DIGIT, 32'h76543210);
        ref_digit = 32'h76543210;
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); #1;
            k = edge_cnt; i = ((k - 1) / SCAN_DIV) % 8;
            tests_run++;
            if (dig_en !== ~(8'h01 << i) || dig_seg !== glyph[(ref_digit >> (4 * i)) & 32'hF]) begin
                tests_failed++;
                $display("FAIL scan edge %0d got en=%h seg=%h want en=%h seg=%h", k, dig_en, dig_seg,
                         ~(8'h01 << i), glyph[(ref_digit >> (4 * i)) & 32'hF]);
            end
        end
    endtask

    // DIGIT store landing on the same edge as an idx advance.
    task automatic test_digit_on_advance();
        int k;
        int i;
        logic [31:0] old_digit;
        logic [31:0] new_digit;
        old_digit = ref_digit;
        new_digit = 32'hFEDCBA98;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (edge_cnt % SCAN_DIV == SCAN_DIV - 1) break;
        end
        do_store(A_DIGIT, new_digit);
        ref_digit = new_digit;
        #1;
        k = edge_cnt; i = ((k - 1) / SCAN_DIV) % 8;
        tests_run++;
        if (dig_en !== ~(8'h01 << i) || dig_seg !== glyph[(old_digit >> (4 * i)) & 32'hF]) begin
            tests_failed++;
            $display("FAIL adv_same_edge got en=%h seg=%h want en=%h seg=%h", dig_en, dig_seg,
                     ~(8'h01 << i), glyph[(old_digit >> (4 * i)) & 32'hF]);
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk); #1;
            k = edge_cnt; i = ((k - 1) / SCAN_DIV) % 8;
            tests_run++;
            if (dig_en !== ~(8'h01 << i) || dig_seg !== glyph[(ref_digit >> (4 * i)) & 32'hF]) begin
                tests_failed++;
                $display("FAIL adv_after edge %0d got en=%h seg=%h want en=%h seg=%h", k, dig_en, dig_seg,
                         ~(8'h01 << i), glyph[(ref_digit >> (4 * i)) & 32'hF]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
        d1 = $urandom; d2 = $urandom; d3 = $urandom;
        @(negedge clk);
        dram_we = 1'b1; addr = A_LED; write_data = d1;
        @(negedge clk);
        addr = A_DIGIT; write_data = d2; ref_led = d1[23:0]; #1;
        tests_run++; if (led !== ref_led) begin tests_failed++; $display("FAIL b2b_led got %h want %h", led, ref_led); end
        tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL b2b_digit_ram_we got %b want 0", ram_we); end
        @(negedge clk);
        addr = 32'h0000_0100; write_data = d3; ref_digit = d2; #1;
        tests_run++; if (ram_we !== 1'b1 || ram_wdata !== d3) begin tests_failed++; $display("FAIL b2b_ram got we=%b wd=%h want we=1 wd=%h", ram_we, ram_wdata, d3); end
        @(negedge clk);
        dram_we = 1'b0; addr = A_DIGIT; #1;
        tests_run++; if (read_data !== ref_digit) begin tests_failed++; $display("FAIL b2b_digit got %h want %h", read_data, ref_digit); end
        tests_run++; if (led !== ref_led) begin tests_failed++; $display("FAIL b2b_led_kept got %h want %h", led, ref_led); end
    endtask

    task automatic test_reset_mid();
        int k;
        int i;
        @(negedge clk);
        do_store(A_LED, $urandom | 32'h1);
        do_store(A_DIGIT, $urandom | 32'h10);
        repeat (5) @(negedge clk);
        // Store in flight when reset hits, held through the next rising edge.
        dram_we = 1'b1; addr = A_LED; write_data = 32'h00ABCDEF;
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (led !== 24'h0) begin tests_failed++; $display("FAIL rstmid_led got %h want 000000", led); end
        tests_run++; if (dig_en !== 8'hFE) begin tests_failed++; $display("FAIL rstmid_dig_en got %h want fe", dig_en); end
        tests_run++; if (dig_seg !== 8'h03) begin tests_failed++; $display("FAIL rstmid_dig_seg got %h want 03", dig_seg); end
        @(negedge clk); #1;
        tests_run++; if (led !== 24'h0) begin tests_failed++; $display("FAIL rstmid_store_blocked got %h want 000000", led); end
        addr = 32'h0000_0040; #1;
        tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ram_we got %b want 0", ram_we); end
        dram_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ref_led = 24'h0; ref_digit = 32'h0;
        addr = A_DIGIT; #1;
        tests_run++; if (read_data !== 32'h0) begin tests_failed++; $display("FAIL rstmid_digit got %h want 0", read_data); end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            k = edge_cnt; i = ((k - 1) / SCAN_DIV) % 8;
            tests_run++;
            if (dig_en !== ~(8'h01 << i) || dig_seg !== 8'h03) begin
                tests_failed++;
                $display("FAIL rstmid_scan edge %0d got en=%h seg=%h want en=%h seg=03", k, dig_en, dig_seg, ~(8'h01 << i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led();
        test_digit();
        test_sync();
        test_unmapped();
        test_scan();
        test_digit_on_advance();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_bus_bridge

// File: doc/bus_bridge.md
BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles spent on each seven-segment digit position.
REQ-002 Parameter RAM_AW, default 14: data RAM word-address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 dram_we  input  1  CPU MEM-stage store strobe.
REQ-006 addr  input  32  CPU byte address; the CPU only issues word accesses.
REQ-007 write_data  input  32  CPU store data.
REQ-008 read_data  output  32  load data returned to the CPU in the same cycle.
REQ-009 ram_we  output  1  data-RAM write enable.
REQ-010 ram_addr  output  RAM_AW  data-RAM word address.
REQ-011 ram_wdata  output  32  data-RAM write data.
REQ-012 ram_rdata  input  32  data-RAM combinational read data.
REQ-013 sw  input  24  board switches; asynchronous to clk.
REQ-014 button  input  5  board buttons; asynchronous to clk.
REQ-015 led  output  24  registered LED drive.
REQ-016 dig_en  output  8  seven-segment digit enables, active-low, one-hot-zero.
REQ-017 dig_seg  output  8  segment drive {a,b,c,d,e,f,g,dp}, active-low.

Function
REQ-018 Peripheral select: addr[31:12]==20'hFFFFF; any other address selects RAM.
REQ-019 RAM path: ram_addr = addr[RAM_AW+1:2]; ram_wdata = write_data; ram_we = dram_we when RAM is selected, else 0.
REQ-020 Peripheral offsets addr[11:0]: 0x000 DIGIT (read/write, 32 bits); 0x060 LED (read/write, low 24 bits); 0x070 SW (read-only, 24 bits); 0x078 BTN (read-only, 5 bits).
REQ-021 read_data is combinational: it is ram_rdata when RAM is selected, otherwise the addressed register zero-extended to 32 bits.
REQ-022 A read of an unmapped peripheral offset returns 32'h0; a write to it is ignored; neither produces an error.
REQ-023 A write to a read-only offset is ignored.
REQ-024 A store to DIGIT or LED updates the register on the clk edge that ends the store cycle; the new value is visible on read_data and on led / dig_seg from the next cycle.
REQ-025 sw and button pass through 2-flop synchronizers; a pin change is visible on read_data exactly 2 clk edges later.
REQ-026 Scan counter counts 0..SCAN_DIV-1; on its terminal count it wraps to 0 and digit index idx advances by 1, wrapping from 7 to 0.
REQ-027 dig_en = ~(8'b1 << idx); dig_seg = hex decode of DIGIT[4*idx+3:4*idx].
REQ-028 Outputs dig_en and dig_seg are registered, so a change in idx or DIGIT reaches them one cycle later.
REQ-029 Hex decode uses the standard 16-glyph set; '0'->8'h03, '1'->8'h9F, '8'->8'h01, 'F'->8'h71; dp is always off (1).
REQ-030 A DIGIT write that coincides with an idx advance does not disturb scan timing; the display uses the new DIGIT value from the following cycle.
REQ-031 SCAN_DIV==1 advances idx every cycle.

Reset
REQ-032 While rst_n is low: led=0, DIGIT=0, scan counter=0, idx=0, dig_en=8'hFE, dig_seg=8'h03, synchronizers=0.
REQ-033 Reset asserted mid-scan or mid-store clears all state immediately; no store completes in that cycle.
REQ-034 ram_we is 0 whenever dram_we is 0, including during reset.

Structure
REQ-035 The shared package holds the peripheral base 20'hFFFFF, the four offset constants and the segment glyph table.
REQ-036 Hex-to-segment decoding is a sub-module seg7_decode (4-bit input, 8-bit active-low output).

Verification
REQ-037 Store to 0x0000_0010 with write_data=32'hDEADBEEF -> ram_we=1, ram_addr=4, no change to led; a following load returns ram_rdata.
REQ-038 Store to 0xFFFF_F060 with write_data=32'hFF123456 -> led=24'h123456 next cycle; load of 0xFFFF_F060 returns 32'h00123456; ram_we stays 0.
REQ-039 Drive sw=24'hA5A5A5 -> load of 0xFFFF_F070 returns 32'h00A5A5A5 from the 2nd edge onward, old value before that; load of 0xFFFF_F07C returns 0.
REQ-040 SCAN_DIV=4, DIGIT=32'h76543210 -> dig_en steps FE,FD,...,7F,FE every 4 cycles; dig_seg=8'h03 at FE and 8'h9F at FD.
REQ-041 Pulse rst_n low mid-scan after LED/DIGIT writes -> outputs return at once to the REQ-032 values; the scan restarts from idx 0.
